rv32i_decode_stage: RTL and testbench
=====================================

Name: rv32i_decode_stage

Overview:
- Registered RV32I decode stage between fetch and ALU/register file.
- Decodes all six base formats (R, I, S, B, U, J) into a fixed opcode bundle, register indices and sign-extended immediate.
- Decoded results sit in a parametrised FIFO with valid/ready handshakes on both sides and a synchronous flush for branch redirect.

Parameters:
- XLEN, 32: data and PC width. Immediates are sign-extended to XLEN.
- DEPTH, 2: number of buffered decoded entries. Legal range is 1..16; non-power-of-two values are legal.
- CNT_W, $clog2(DEPTH+1): width of the occupancy counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  fetch presents instr/pc.
- in_ready  out  1  stage can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_opcode  out  17  {funct7, funct3, opcode[6:0]}.
- out_fmt  out  3  format code (package enum).
- out_rd  out  5  destination register.
- out_rs1  out  5  source register 1.
- out_rs2  out  5  source register 2.
- out_imm  out  XLEN  sign-extended immediate.
- out_pc  out  XLEN  pc of head entry.
- out_count  out  CNT_W  current occupancy.

Behaviour:
- Reset (async): count=0, read/write pointers=0.
  - out_valid=0, in_ready=1.
  - All out_* data fields read 0 while empty (data are masked when out_valid=0).
- Handshakes:
  - Enqueue when in_valid&&in_ready.
  - Dequeue when out_valid&&out_ready.
  - in_ready = (count<DEPTH). in_ready has no combinational dependence on out_ready, so no same-cycle push into a full buffer.
  - out_valid = (count!=0).
- Latency: an instruction accepted at edge N is visible at the head after edge N (one cycle), if the buffer was empty.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap from DEPTH-1 to 0.
- flush: count←0 and pointers←0 at the next edge. It overrides a simultaneous push and pop; the pushed instruction is dropped even though in_ready was 1.
- Decode, performed combinationally before the FIFO write:
  - R (0110011): opcode = {instr[31:25], f3, op}; rd, rs1, rs2 from instr; imm=0.
  - I-ALU (0010011):
    - f3=001 or 101: funct7=instr[31:25]; imm=zero-extended instr[24:20].
    - Otherwise: funct7=0; imm=sext(instr[31:20]).
    - rs2=0.
  - I-load (0000011), JALR (1100111): funct7=0; imm=sext(instr[31:20]); rs2=0.
  - S (0100011): imm = sext({instr[31:25], instr[11:7]}); rd=0.
  - B (1100011): imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}); rd=0.
  - U (0110111, 0010111): imm = {instr[31:12], 12'b0}, sign-extended to XLEN; funct3=0; rs1=rs2=0.
  - J (1101111): imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}); funct3=0; rs1=rs2=0.
  - Any other opcode: fmt=FMT_NONE; rd/rs1/rs2/imm=0; opcode field = {10'b0, op}.
  - Unused fields are always driven 0. No latches, no stale values.
- Reset asserted mid-transfer: buffer emptied immediately; in-flight handshakes are void.

Optional Feature:
- Macro: RV32I_DECODE_ILLEGAL_EN.
- Defined: adds output port out_illegal (1 bit), stored per entry. It is set when any of these holds:
  - The opcode is not in the list above.
  - instr[1:0]!=2'b11.
  - R-type funct7 is not in {0000000, 0100000}.
  - For 0100000, funct3 is not in {000, 101}.
  - A shift-immediate has an illegal funct7.
  - Illegal entries still flow through the FIFO; out_illegal is 0 when the buffer is empty.
- Undefined: port absent; behaviour is otherwise identical.

Decomposition:
- Package rv32i_pkg:
  - Opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - Enum fmt_t (FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J; 3 bits).
  - Packed struct dec_t holding the FIFO entry.
- Sub-module rv32i_field_decode: purely combinational instr→dec_t. The stage instantiates it once and owns the FIFO.

Test Plan:
- After reset, push 0x002081B3 (add x3,x1,x2) with out_ready=1 → next cycle out_valid=1, opcode=17'h00033, rd=3, rs1=1, rs2=2, imm=0, fmt=FMT_R.
- Push 0xFFF00093 (addi x1,x0,-1) → rd=1, rs1=0, rs2=0, imm=0xFFFFFFFF. Then push 0x40335293 (srai x5,x6,3) → opcode=17'h08293, imm=3.
- Push 0x008000EF (jal x1,+8) → fmt=FMT_J, rd=1, imm=8. Push 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC, rd=0.
- DEPTH=2, out_ready=0, three back-to-back pushes → in_ready drops after the 2nd accept, count=2, 3rd held. Raise out_ready → order preserved, 3rd accepted after the first pop.
- Two entries buffered; assert flush together with in_valid → next cycle count=0, out_valid=0, flushed instruction never emerges.
- With RV32I_DECODE_ILLEGAL_EN: push 0x00000000 → out_illegal=1, fmt=FMT_NONE. Push 0x002081B3 → out_illegal=0. Reset mid-stream → out_valid=0 asynchronously.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: base opcodes, format enum and the decoded FIFO entry.
// The entry carries an illegal flag only when RV32I_DECODE_ILLEGAL_EN is defined.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_t;

    // Immediates are kept at 32 bits in the buffer and widened to XLEN on the way out.
    typedef struct packed {
        logic [16:0] opcode;
        fmt_t        fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
`ifdef RV32I_DECODE_ILLEGAL_EN
        logic        illegal;
`endif
    } dec_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/rv32i_decode_stage_if.sv
// Fetch-side and consumer-side handshake bundle of the decode stage.
// out_illegal exists only when RV32I_DECODE_ILLEGAL_EN is defined.
interface rv32i_decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    import rv32i_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [16:0]      out_opcode;
    fmt_t             out_fmt;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [XLEN-1:0]  out_imm;
    logic [XLEN-1:0]  out_pc;
    logic [CNT_W-1:0] out_count;
`ifdef RV32I_DECODE_ILLEGAL_EN
    logic             out_illegal;
`endif

    modport master (
`ifdef RV32I_DECODE_ILLEGAL_EN
        input  out_illegal,
`endif
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_opcode, out_fmt, out_rd, out_rs1,
               out_rs2, out_imm, out_pc, out_count
    );

    modport slave (
`ifdef RV32I_DECODE_ILLEGAL_EN
        output out_illegal,
`endif
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_opcode, out_fmt, out_rd, out_rs1,
               out_rs2, out_imm, out_pc, out_count
    );

endinterface

// File: rtl/rv32i_field_decode.sv
// Purely combinational RV32I field decoder: raw instruction to dec_t entry.
// Illegal-instruction detection is compiled in with RV32I_DECODE_ILLEGAL_EN.
module rv32i_field_decode
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;

    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

`ifdef RV32I_DECODE_ILLEGAL_EN
    logic ill;

    always_comb begin
        ill = 1'b0;
        case (op)
            OP_R:   ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
            OP_IMM: begin
                if (f3 == 3'b001)
                    ill = (f7 != 7'h00);
                else if (f3 == 3'b101)
                    ill = !(f7 == 7'h00 || f7 == 7'h20);
            end
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: ill = 1'b0;
            default: ill = 1'b1;
        endcase
        if (instr[1:0] != 2'b11)
            ill = 1'b1;
    end
`endif

    // Every field starts at zero so formats that do not use a field never leak raw bits.
    always_comb begin
        dec        = '0;
        dec.fmt    = FMT_NONE;
        dec.opcode = {10'b0, op};
        case (op)
            OP_R: begin
                dec.fmt    = FMT_R;
                dec.opcode = {f7, f3, op};
                dec.rd     = instr[11:7];
                dec.rs1    = instr[19:15];
                dec.rs2    = instr[24:20];
            end
            OP_IMM: begin
                dec.fmt = FMT_I;
                dec.rd  = instr[11:7];
                dec.rs1 = instr[19:15];
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec.opcode = {f7, f3, op};
                    dec.imm    = {27'b0, instr[24:20]};
                end else begin
                    dec.opcode = {7'b0, f3, op};
                    dec.imm    = sext12(instr[31:20]);
                end
            end
            OP_LOAD, OP_JALR: begin
                dec.fmt    = FMT_I;
                dec.opcode = {7'b0, f3, op};
                dec.rd     = instr[11:7];
                dec.rs1    = instr[19:15];
                dec.imm    = sext12(instr[31:20]);
            end
            OP_STORE: begin
                dec.fmt    = FMT_S;
                dec.opcode = {7'b0, f3, op};
                dec.rs1    = instr[19:15];
                dec.rs2    = instr[24:20];
                dec.imm    = sext12({instr[31:25], instr[11:7]});
            end
            OP_BRANCH: begin
                dec.fmt    = FMT_B;
                dec.opcode = {7'b0, f3, op};
                dec.rs1    = instr[19:15];
                dec.rs2    = instr[24:20];
                dec.imm    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec.fmt = FMT_U;
                dec.rd  = instr[11:7];
                dec.imm = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                dec.fmt = FMT_J;
                dec.rd  = instr[11:7];
                dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: ;
        endcase
`ifdef RV32I_DECODE_ILLEGAL_EN
        dec.illegal = ill;
`endif
    end

endmodule

// File: rtl/rv32i_decode_stage.sv
// Registered RV32I decode stage: field decoder feeding a DEPTH-entry FIFO with flush.
// Define RV32I_DECODE_ILLEGAL_EN to carry a per-entry illegal flag to out_illegal.
module rv32i_decode_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    rv32i_decode_stage_if.slave bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dec_t             dec_in;
    dec_t             head;
    dec_t             mem_q    [DEPTH];
    logic [XLEN-1:0]  pc_mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    rv32i_field_decode u_field_decode (
        .instr (bus.in_instr),
        .dec   (dec_in)
    );

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign bus.in_ready  = (count_q < CNT_W'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // Flush wins over any simultaneous push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)
                wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)
                rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            mem_q[wr_ptr_q]    <= dec_in;
            pc_mem_q[wr_ptr_q] <= bus.in_pc;
        end
    end

    // Storage is not reset, so every data output is masked while the buffer is empty.
    assign head           = mem_q[rd_ptr_q];
    assign bus.out_opcode = bus.out_valid ? head.opcode : '0;
    assign bus.out_fmt    = bus.out_valid ? head.fmt : FMT_NONE;
    assign bus.out_rd     = bus.out_valid ? head.rd : '0;
    assign bus.out_rs1    = bus.out_valid ? head.rs1 : '0;
    assign bus.out_rs2    = bus.out_valid ? head.rs2 : '0;
    assign bus.out_imm    = bus.out_valid ? XLEN'($signed(head.imm)) : '0;
    assign bus.out_pc     = bus.out_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign bus.out_count  = count_q;
`ifdef RV32I_DECODE_ILLEGAL_EN
    assign bus.out_illegal = bus.out_valid ? head.illegal : 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Scoreboard bench for rv32i_decode_stage: directed vectors, decoupled output monitor.
// Checks out_illegal too when RV32I_DECODE_ILLEGAL_EN is defined.
module tb_rv32i_decode_stage;
    import rv32i_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rv32i_decode_stage_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    rv32i_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [16:0] opcode;
        fmt_t        fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic exp_t mk(input logic [16:0] op, input fmt_t f, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic ill);
        exp_t e;
        e.opcode  = op;
        e.fmt     = f;
        e.rd      = rd;
        e.rs1     = rs1;
        e.rs2     = rs2;
        e.imm     = imm;
        e.pc      = '0;
        e.illegal = ill;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the instruction.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
        int waited;
        waited       = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("accept_wait", 64'(bus.in_ready), 64'd1);
        e.pc = pc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got opcode 0x%0h pc 0x%0h expected no entry", bus.out_opcode, bus.out_pc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("opcode", 64'(bus.out_opcode), 64'(mon_e.opcode));
                checkOutput("fmt",    64'(bus.out_fmt),    64'(mon_e.fmt));
                checkOutput("rd",     64'(bus.out_rd),     64'(mon_e.rd));
                checkOutput("rs1",    64'(bus.out_rs1),    64'(mon_e.rs1));
                checkOutput("rs2",    64'(bus.out_rs2),    64'(mon_e.rs2));
                checkOutput("imm",    64'(bus.out_imm),    64'(mon_e.imm));
                checkOutput("pc",     64'(bus.out_pc),     64'(mon_e.pc));
`ifdef RV32I_DECODE_ILLEGAL_EN
                checkOutput("illegal", 64'(bus.out_illegal), 64'(mon_e.illegal));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;

        #12;
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_in_ready",  64'(bus.in_ready),  64'd1);
        checkOutput("rst_count",     64'(bus.out_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("empty_opcode", 64'(bus.out_opcode), 64'd0);
        checkOutput("empty_imm",    64'(bus.out_imm),    64'd0);
        checkOutput("empty_pc",     64'(bus.out_pc),     64'd0);
        checkOutput("empty_rd",     64'(bus.out_rd),     64'd0);
`ifdef RV32I_DECODE_ILLEGAL_EN
        checkOutput("empty_illegal", 64'(bus.out_illegal), 64'd0);
`endif

        // Streaming with out_ready high: push and pop in the same cycle, pointers wrap.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        fork
            begin
                applyStimulus(32'h002081B3, 32'h1000, mk(17'h00033, FMT_R, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0));
                applyStimulus(32'hFFF00093, 32'h1004, mk(17'h00013, FMT_I, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0));
                applyStimulus(32'h40335293, 32'h1008, mk(17'h08293, FMT_I, 5'd5, 5'd6, 5'd0, 32'h3, 1'b0));
                applyStimulus(32'h008000EF, 32'h100C, mk(17'h0006F, FMT_J, 5'd1, 5'd0, 5'd0, 32'h8, 1'b0));
                applyStimulus(32'hFE000EE3, 32'h1010, mk(17'h00063, FMT_B, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0));
                applyStimulus(32'hFFFFF517, 32'h1014, mk(17'h00017, FMT_U, 5'd10, 5'd0, 5'd0, 32'hFFFFF000, 1'b0));
                applyStimulus(32'h00008067, 32'h1018, mk(17'h00067, FMT_I, 5'd0, 5'd1, 5'd0, 32'h0, 1'b0));
            end
            begin
                @(negedge clk);
                checkOutput("latency_before", 64'(bus.out_valid), 64'd0);
                @(negedge clk);
                checkOutput("latency_after", 64'(bus.out_valid), 64'd1);
                @(negedge clk);
                checkOutput("stream_count", 64'(bus.out_count), 64'd1);
                checkOutput("stream_in_ready", 64'(bus.in_ready), 64'd1);
            end
        join
        drain();

        // Backpressure: two accepts fill the buffer, the third waits for the first pop.
        bus.out_ready = 1'b0;
        fork
            begin
                applyStimulus(32'hFF83A303, 32'h2000, mk(17'h00103, FMT_I, 5'd6, 5'd7, 5'd0, 32'hFFFFFFF8, 1'b0));
                applyStimulus(32'h01F09093, 32'h2004, mk(17'h00093, FMT_I, 5'd1, 5'd1, 5'd0, 32'd31, 1'b0));
                applyStimulus(32'h123452B7, 32'h2008, mk(17'h00037, FMT_U, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0));
            end
            begin
                repeat (4) @(negedge clk);
                checkOutput("full_count",     64'(bus.out_count), 64'd2);
                checkOutput("full_in_ready",  64'(bus.in_ready),  64'd0);
                checkOutput("full_out_valid", 64'(bus.out_valid), 64'd1);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Flush with a full buffer while fetch still presents an instruction.
        bus.out_ready = 1'b0;
        applyStimulus(32'h00112623, 32'h3000, mk(17'h00123, FMT_S, 5'd0, 5'd2, 5'd1, 32'd12, 1'b0));
        applyStimulus(32'hFFFFFFFF, 32'h3004, mk(17'h0007F, FMT_NONE, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1));
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h022081B3;
        bus.in_pc    = 32'h3008;
        @(negedge clk);
        checkOutput("flush_full_in_ready", 64'(bus.in_ready), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_count",     64'(bus.out_count),  64'd0);
        checkOutput("flush_out_valid", 64'(bus.out_valid),  64'd0);
        checkOutput("flush_opcode",    64'(bus.out_opcode), 64'd0);

        // Flush with room left: the offered instruction is dropped even though in_ready is 1.
        @(posedge clk);
        #1;
        applyStimulus(32'h40335293, 32'h4000, mk(17'h08293, FMT_I, 5'd5, 5'd6, 5'd0, 32'h3, 1'b0));
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00000000;
        bus.in_pc    = 32'h4004;
        @(negedge clk);
        checkOutput("flush_part_in_ready", 64'(bus.in_ready), 64'd1);
        sb.delete();
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_part_count", 64'(bus.out_count), 64'd0);

        // Traffic after the flushes: anything flushed would surface ahead of these.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        applyStimulus(32'h00112623, 32'h5000, mk(17'h00123, FMT_S, 5'd0, 5'd2, 5'd1, 32'd12, 1'b0));
        applyStimulus(32'hFFFFFFFF, 32'h5004, mk(17'h0007F, FMT_NONE, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1));
        applyStimulus(32'h022081B3, 32'h5008, mk(17'h00433, FMT_R, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1));
        applyStimulus(32'h00000000, 32'h500C, mk(17'h00000, FMT_NONE, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1));
        applyStimulus(32'h002081B3, 32'h5010, mk(17'h00033, FMT_R, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0));
        drain();

        // Asynchronous reset with an entry buffered.
        bus.out_ready = 1'b0;
        applyStimulus(32'hFFF00093, 32'h6000, mk(17'h00013, FMT_I, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("async_rst_count",     64'(bus.out_count), 64'd0);
        checkOutput("async_rst_in_ready",  64'(bus.in_ready),  64'd1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        applyStimulus(32'h008000EF, 32'h7000, mk(17'h0006F, FMT_J, 5'd1, 5'd0, 5'd0, 32'h8, 1'b0));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
